// File: rtl/axi_rd_if.sv
// AXI3 read-address and read-data channel bundle.
// Signals:
//   AR channel: arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, arready.
//   R channel:  rid, rdata, rresp, rlast, rvalid, rready.
// Modports: master (read master side), slave (interconnect/memory side).
interface axi_rd_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_rd.sv
// AXI3 read master for cache refills (full-line INCR burst) and uncached single-beat loads.
// One request at a time: latch it, wait for the write master to go idle, issue AR, collect
// R beats into a line buffer, then pulse rd_valid_o for one cycle.
// Ports:
//   clk_i, reset_i     clock and synchronous active-high reset
//   rd_req_i/rd_rdy_o  request handshake (accepted when both high)
//   burst_i, addr_i, size_i  request kind, byte address, single-beat size (log2 bytes)
//   rd_valid_o, rd_data_o    one-cycle completion pulse and assembled line
//   wr_idle_i          write master idle; AR is held back until it is high
//   read_unfinish_o    AR issued or R beats outstanding
//   rd_err_o           only with AXI_RD_RESP_CHECK_EN: sticky response/rlast error flag
//   axi_io             AXI AR/R channels (master modport)
// Optional feature macro: AXI_RD_RESP_CHECK_EN.
module axi_rd #(
  parameter int unsigned D_BYTES_PER_LINE = 16,
  parameter int unsigned D_WORDS_PER_LINE = D_BYTES_PER_LINE / 4,
  parameter int unsigned D_BANK_NUM_WIDTH = $clog2(D_WORDS_PER_LINE),
  parameter int unsigned D_LINE_WIDTH     = D_WORDS_PER_LINE * 32,
  parameter logic [3:0]  AXI_ID           = 4'd0
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    rd_req_i,
  output logic                    rd_rdy_o,
  input  logic                    burst_i,
  input  logic [31:0]             addr_i,
  input  logic [1:0]              size_i,
  output logic                    rd_valid_o,
  output logic [D_LINE_WIDTH-1:0] rd_data_o,
  input  logic                    wr_idle_i,
  output logic                    read_unfinish_o,
`ifdef AXI_RD_RESP_CHECK_EN
  output logic                    rd_err_o,
`endif
  axi_rd_if.master                axi_io
);

  localparam int unsigned OffW = $clog2(D_BYTES_PER_LINE);

  typedef enum logic [2:0] {StIdle, StWaitWr, StAr, StR, StDone} state_e;

  state_e                      state_q, state_d;
  logic [D_BANK_NUM_WIDTH-1:0] ptr_q;
  logic [31:0]                 addr_q;
  logic                        burst_q;
  logic [1:0]                  size_q;
  logic [D_LINE_WIDTH-1:0]     line_q;
  logic                        last_beat;
  logic                        accept;
  logic                        beat;

  assign accept    = (state_q == StIdle) && rd_req_i;
  assign beat      = (state_q == StR) && axi_io.rvalid;
  // Termination is by beat count against arlen, never by rlast.
  assign last_beat = burst_q ? (ptr_q == {D_BANK_NUM_WIDTH{1'b1}}) : (ptr_q == '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (rd_req_i)              state_d = StWaitWr;
      StWaitWr: if (wr_idle_i)             state_d = StAr;
      StAr:     if (axi_io.arready)        state_d = StR;
      StR:      if (beat && last_beat)     state_d = StDone;
      StDone:                              state_d = StIdle;
      default:                             state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      addr_q  <= '0;
      burst_q <= 1'b0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        addr_q  <= addr_i;
        burst_q <= burst_i;
        size_q  <= size_i;
        ptr_q   <= '0;
      end else if (beat) begin
        ptr_q <= ptr_q + 1'b1;
      end
    end
  end

  // Line buffer has no reset: contents are meaningless until the first completion.
  always_ff @(posedge clk_i) begin
    if (beat) begin
      line_q[{ptr_q, 5'd0} +: 32] <= axi_io.rdata;
    end
  end

`ifdef AXI_RD_RESP_CHECK_EN
  logic err_q;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= 1'b0;
    end else if (beat) begin
      err_q <= err_q | (axi_io.rresp != 2'b00) | (axi_io.rlast != last_beat);
    end
  end
  assign rd_err_o = err_q;
  logic unused_rid;
  assign unused_rid = ^axi_io.rid;
`else
  logic unused_r;
  assign unused_r = ^{axi_io.rid, axi_io.rresp, axi_io.rlast};
`endif

  assign rd_rdy_o        = (state_q == StIdle);
  assign rd_valid_o      = (state_q == StDone);
  assign rd_data_o       = line_q;
  // Deliberately excludes StWaitWr so the writer and reader can never wait on each other.
  assign read_unfinish_o = (state_q == StAr) || (state_q == StR);

  assign axi_io.arvalid = (state_q == StAr);
  assign axi_io.rready  = (state_q == StR);
  assign axi_io.araddr  = burst_q ? {addr_q[31:OffW], {OffW{1'b0}}} : addr_q;
  assign axi_io.arlen   = burst_q ? 8'(D_WORDS_PER_LINE - 1) : 8'd0;
  assign axi_io.arsize  = burst_q ? 3'd2 : {1'b0, size_q};
  assign axi_io.arburst = burst_q ? 2'b01 : 2'b00;
  assign axi_io.arid    = AXI_ID;
  assign axi_io.arlock  = 2'b00;
  assign axi_io.arcache = 4'b0000;
  assign axi_io.arprot  = 3'b000;

endmodule

// File: doc/axi_rd.md
Name: axi_rd

Overview:
- AXI3 read master that serves cache refills and uncached loads.
- Accepts one request at a time from the cache side: either a full-line burst refill or a single beat.
- Issues AR, collects R beats into a line buffer and returns the assembled line with a one-cycle valid pulse.
- Coordinates with the write master: holds AR while the write path is busy, and reports an in-flight read so the writer does not start during it.

Parameters:
- D_BYTES_PER_LINE, 16, cache line size in bytes.
- D_WORDS_PER_LINE, D_BYTES_PER_LINE/4, 32-bit words per line.
- D_BANK_NUM_WIDTH, $clog2(D_WORDS_PER_LINE), beat pointer width.
- D_LINE_WIDTH, D_WORDS_PER_LINE*32, line buffer width.
- AXI_ID, 4'd0, constant value driven on arid.

Ports:
- clk  in  1  clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  request; accepted when rd_req & rd_rdy.
- rd_rdy  out  1  block is IDLE and can accept a request.
- burst  in  1  1 = line refill, 0 = single beat.
- addr  in  32  request byte address.
- size  in  2  single-beat size (log2 bytes).
- rd_valid  out  1  one-cycle pulse: rd_data is complete.
- rd_data  out  D_LINE_WIDTH  assembled line; word i sits at bits [32i+31:32i].
- wr_idle  in  1  write master has an empty buffer and is idle.
- read_unfinish  out  1  AR issued or R beats still outstanding.
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arvalid  out  4/32/8/3/2/2/4/3/1  AXI AR channel.
- arready  in  1  AXI AR channel.
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1  AXI R channel.
- rready  out  1  AXI R channel.

Behaviour:
- States: IDLE, WAIT_WR, AR, R, DONE.
- Reset:
  - state=IDLE, beat pointer=0.
  - Outputs: rd_rdy=1, rd_valid=0, arvalid=0, rready=0, read_unfinish=0.
  - rd_data contents undefined until the first DONE.
- IDLE:
  - rd_rdy=1.
  - On rd_req, latch addr/burst/size, clear beat pointer, go to WAIT_WR.
- WAIT_WR:
  - Go to AR on the first cycle with wr_idle=1; otherwise stay.
  - The wait is 0 cycles if wr_idle is already 1, giving request-to-arvalid latency of 2 cycles.
- AR:
  - arvalid=1. AR fields are driven from the latched values and are stable while arvalid=1.
  - On arready go to R. arvalid stays high until the handshake.
- R:
  - rready=1.
  - Each rvalid beat writes rdata into word[ptr], then ptr+1.
  - Last beat is the handshake with ptr == arlen (ptr all-ones for burst, 0 for single). On it go to DONE.
  - rlast is not used for termination.
- DONE: rd_valid=1 for exactly one cycle, then go to IDLE.
- read_unfinish = state is AR or R.
  - Never asserted in WAIT_WR, which rules out writer/reader deadlock.
- Burst request:
  - araddr = addr with low $clog2(D_BYTES_PER_LINE) bits cleared.
  - arlen = D_WORDS_PER_LINE-1, arsize=3'd2, arburst=INCR(01).
- Single-beat request:
  - araddr = addr, arlen=0, arsize={1'b0,size}, arburst=FIXED(00).
  - Result lands in word 0; other words keep their previous values.
- Tie-offs: arid=AXI_ID, arlock=0, arcache=0, arprot=0.
- rd_data holds its value after DONE until the next accepted request's first beat.
- rd_req outside IDLE is ignored; the requester must hold it until rd_rdy.
- Beat pointer wraps naturally at D_BANK_NUM_WIDTH bits; no overflow logic.
- Reset mid-transaction:
  - Returns to IDLE immediately and drops arvalid/rready.
  - The interconnect is reset together with this block, so no drain is performed.

Optional Feature:
- Macro AXI_RD_RESP_CHECK_EN.
- Defined:
  - Adds output rd_err (1 bit, reset 0).
  - rd_err is sticky-ORed over the transaction for any accepted beat with rresp!=0, or with rlast mismatching the computed last beat.
  - rd_err is valid alongside rd_valid and clears on the next accepted rd_req.
- Undefined: no rd_err port; rresp and rlast are ignored.

Test Plan:
- Burst refill, wr_idle=1, addr=0x1000_0014:
  - araddr=0x1000_0010, arlen=3, arsize=2, arburst=01.
  - Beats 0xA0..0xA3 produce rd_data={A3,A2,A1,A0}, then one rd_valid pulse.
- Single read, addr=0x1FC0_0002, size=1:
  - arlen=0, arsize=1, arburst=00.
  - rdata=0x1234_5678 lands in word 0; rd_valid follows 1 cycle after the beat.
- wr_idle held 0 for 5 cycles after the request: arvalid stays 0 and read_unfinish stays 0; arvalid rises the cycle after wr_idle=1.
- arready delayed 3 cycles, then rvalid gaps between beats: arvalid is held, read_unfinish=1 throughout AR and R, and the data still assembles in order.
- reset asserted during R after 2 beats: next cycle state=IDLE, rd_rdy=1, rready=0, and a new burst then completes normally.
- With AXI_RD_RESP_CHECK_EN defined: a burst with rresp=2'b10 on beat 1 gives rd_err=1 with rd_valid, and rd_err clears on the next request.
